// File: rtl/cac_fns_enc_seq_if.sv
// Handshake bus for the Fibonacci-weighted CAC encoder: one word in, one codeword + error flag out.
interface cac_fns_enc_seq_if #(parameter int N = 8);
  function automatic int fib(input int n);
    int a = 1;
    int b = 1;
    int t;
    for (int i = 3; i <= n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  localparam int BLEN = $clog2(fib(N + 2));

  logic            in_valid;
  logic            in_ready;
  logic [BLEN-1:0] datain;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    codeout;
  logic            err;

  modport master (output in_valid, datain, out_ready,
                  input  in_ready, out_valid, codeout, err);
  modport slave  (input  in_valid, datain, out_ready,
                  output in_ready, out_valid, codeout, err);
endinterface

// File: rtl/cac_fns_enc_seq.sv
// Sequential Fibonacci-numeral-system CAC encoder: resolves one bit pair per cycle, MSB pair first,
// then holds the codeword until the consumer takes it.
module cac_fns_enc_seq #(
  parameter int N = 8
) (
  input  logic              clock,
  input  logic              rst_n,
  cac_fns_enc_seq_if.slave  bus
);
  function automatic int fib(input int n);
    int a = 1;
    int b = 1;
    int t;
    for (int i = 3; i <= n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  localparam int              BLEN = $clog2(fib(N + 2));
  localparam logic [BLEN-1:0] VMAX = BLEN'(fib(N + 2) - 1);
  localparam int              PW   = $clog2(N / 2);
  localparam int              TW   = 2 ** (PW + 1);

  if (N < 4 || N > 32 || (N % 2) != 0) begin : g_bad_n
    $error("cac_fns_enc_seq: N must be even and within 4..32");
  end

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t          state, state_nx;
  logic [BLEN-1:0] rem;
  logic [PW-1:0]   pidx;
  logic [N-3:0]    acc;
  logic [N-1:0]    code;
  logic            ovf;
  logic            err_q;

  // w_k = F(k+1); table padded to a power of two so the pair index never runs off the end
  logic [BLEN-1:0] w_tab [TW];
  for (genvar k = 0; k < TW; k++) begin : g_w
    assign w_tab[k] = (k < N) ? BLEN'(fib(k + 1)) : '0;
  end

  // Both bits of a pair compare against w_(2p+1); the low bit subtracts only w_(2p)
  logic [BLEN-1:0] w_hi, w_lo, rem_mid, rem_nx;
  logic            b_hi, b_lo;
  logic [1:0]      pair;
  logic [N-1:0]    acc_nx;

  always_comb begin
    w_hi    = w_tab[{pidx, 1'b1}];
    w_lo    = w_tab[{pidx, 1'b0}];
    b_hi    = (rem >= w_hi);
    rem_mid = b_hi ? rem - w_hi : rem;
    b_lo    = (rem_mid >= w_hi);
    rem_nx  = b_lo ? rem_mid - w_lo : rem_mid;
    pair    = ovf ? 2'b11 : {b_hi, b_lo};
    acc_nx  = {acc, pair};
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nx = CALC;
      CALC:    if (pidx == '0)    state_nx = HOLD;
      HOLD:    if (bus.out_ready) state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rem   <= '0;
      pidx  <= '0;
      acc   <= '0;
      code  <= '0;
      ovf   <= 1'b0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          ovf  <= (bus.datain > VMAX);
          rem  <= (bus.datain > VMAX) ? '0 : bus.datain;
          pidx <= PW'(N / 2 - 1);
          acc  <= '0;
        end
        CALC: begin
          acc  <= acc_nx[N-3:0];
          rem  <= rem_nx;
          pidx <= pidx - 1'b1;
          if (pidx == '0) begin
            code  <= acc_nx;
            err_q <= ovf;
          end
        end
        HOLD: if (bus.out_ready) begin
          code  <= '0;
          err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == HOLD);
  assign bus.codeout   = code;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_cac_fns_enc_seq.sv
// Bench for cac_fns_enc_seq: directed vector table, handshake corner cases, random N=8 words and
// exhaustive sweeps for N=4,6,8,10 against a per-bit reference of the encoding rule.
module tb_cac_fns_enc_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  logic sweep_go = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int fib(input int n);
    int a = 1;
    int b = 1;
    int t;
    for (int i = 3; i <= n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  // Bit-by-bit greedy rule straight from the weight/threshold definition
  function automatic longint ref_code(input int n, input longint v);
    longint r = v;
    longint c = 0;
    longint t;
    if (v > longint'(fib(n + 2) - 1)) return (64'd1 << n) - 1;
    for (int k = n - 1; k >= 1; k--) begin
      t = (k % 2 == 1) ? longint'(fib(k + 1)) : longint'(fib(k + 2));
      if (r >= t) begin
        c = c | (64'd1 << k);
        r = r - longint'(fib(k + 1));
      end
    end
    return c | r;
  endfunction

  function automatic longint wsum(input int n, input longint c);
    longint s = 0;
    for (int k = 0; k < n; k++)
      if (c[k]) s = s + longint'(fib(k + 1));
    return s;
  endfunction

  cac_fns_enc_seq_if #(.N(8)) bus();
  cac_fns_enc_seq #(.N(8)) dut (.clock(clk), .rst_n(rst_n), .bus(bus));

  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int NN = 4 + 2 * g;
    localparam int VM = fib(NN + 2) - 1;
    localparam int BL = $clog2(VM + 1);
    logic done = 1'b0;

    cac_fns_enc_seq_if #(.N(NN)) sb();
    cac_fns_enc_seq #(.N(NN)) sd (.clock(clk), .rst_n(rst_n), .bus(sb));

    initial begin
      int lat;
      sb.in_valid  = 1'b0;
      sb.datain    = '0;
      sb.out_ready = 1'b0;
      wait (sweep_go);
      for (int v = 0; v < (1 << BL); v++) begin
        sb.in_valid = 1'b1;
        sb.datain   = BL'(v);
        @(posedge clk); #1;
        sb.in_valid = 1'b0;
        lat = 0;
        while (!sb.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        check($sformatf("sweep%0d_lat v=%0d", NN, v), longint'(lat), longint'(NN / 2));
        check($sformatf("sweep%0d_code v=%0d", NN, v), longint'(sb.codeout), ref_code(NN, longint'(v)));
        check($sformatf("sweep%0d_err v=%0d", NN, v), longint'(sb.err), longint'(v > VM));
        if (v <= VM)
          check($sformatf("sweep%0d_wsum v=%0d", NN, v), wsum(NN, longint'(sb.codeout)), longint'(v));
        sb.out_ready = 1'b1;
        @(posedge clk); #1;
        sb.out_ready = 1'b0;
      end
      done = 1'b1;
    end
  end

  typedef struct {
    logic [5:0] din;
    logic [7:0] code;
    logic       err;
  } vec_t;

  task automatic do_enc(input logic [5:0] v, output logic [7:0] c, output logic e, output int lat);
    int w = 0;
    while (!bus.in_ready && w < 20) begin @(posedge clk); #1; w++; end
    bus.in_valid = 1'b1;
    bus.datain   = v;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("busy_code_zero", longint'(bus.codeout), 0);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    c = bus.codeout;
    e = bus.err;
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    vec_t tbl [6];
    logic [7:0] c;
    logic       e;
    logic [5:0] v;
    int lat, cnt, bad;

    tbl[0] = '{6'd54, 8'hFF, 1'b0};
    tbl[1] = '{6'd20, 8'h3F, 1'b0};
    tbl[2] = '{6'd33, 8'hAA, 1'b0};
    tbl[3] = '{6'd1,  8'h02, 1'b0};
    tbl[4] = '{6'd0,  8'h00, 1'b0};
    tbl[5] = '{6'd60, 8'hFF, 1'b1};

    bus.in_valid  = 1'b0;
    bus.datain    = '0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_in_ready",  longint'(bus.in_ready),  1);
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_codeout",   longint'(bus.codeout),   0);
    check("rst_err",       longint'(bus.err),       0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      do_enc(tbl[i].din, c, e, lat);
      check($sformatf("tbl_lat d=%0d", tbl[i].din), longint'(lat), 4);
      check($sformatf("tbl_code d=%0d", tbl[i].din), longint'(c), longint'(tbl[i].code));
      check($sformatf("tbl_err d=%0d", tbl[i].din), longint'(e), longint'(tbl[i].err));
      take();
      check($sformatf("tbl_idle d=%0d", tbl[i].din), longint'(bus.in_ready), 1);
    end

    // Stall in HOLD while a second word is offered
    do_enc(6'd33, c, e, lat);
    bus.in_valid = 1'b1;
    bus.datain   = 6'd5;
    cnt = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.out_valid && !bus.in_ready && bus.codeout == 8'hAA && !bus.err) cnt++;
    end
    check("hold_stable_cycles", longint'(cnt), 10);
    bus.in_valid = 1'b0;
    take();
    check("hold_release_ready", longint'(bus.in_ready),  1);
    check("hold_release_valid", longint'(bus.out_valid), 0);
    check("hold_release_code",  longint'(bus.codeout),   0);
    bad = 0;
    repeat (6) begin @(posedge clk); #1; if (bus.out_valid) bad++; end
    check("hold_no_second_word", longint'(bad), 0);

    // Back-to-back throughput with both handshakes held high
    bus.in_valid  = 1'b1;
    bus.datain    = 6'd20;
    bus.out_ready = 1'b1;
    cnt = 0;
    while (!bus.out_valid && cnt < 20) begin @(posedge clk); #1; cnt++; end
    check("tput_first_code", longint'(bus.codeout), 8'h3F);
    cnt = 0;
    do begin @(posedge clk); #1; cnt++; end while (!bus.out_valid && cnt < 20);
    check("tput_period", longint'(cnt), 6);
    check("tput_second_code", longint'(bus.codeout), 8'h3F);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;

    // Reset in the second CALC cycle
    bus.in_valid = 1'b1;
    bus.datain   = 6'd54;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready",  longint'(bus.in_ready),  1);
    check("midrst_out_valid", longint'(bus.out_valid), 0);
    check("midrst_codeout",   longint'(bus.codeout),   0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (6) begin @(posedge clk); #1; if (bus.out_valid || bus.codeout != 8'h00) bad++; end
    check("midrst_no_partial", longint'(bad), 0);
    do_enc(6'd20, c, e, lat);
    check("midrst_next_lat",  longint'(lat), 4);
    check("midrst_next_code", longint'(c),   8'h3F);
    take();

    for (int i = 0; i < 40; i++) begin
      v = 6'($urandom_range(0, 63));
      do_enc(v, c, e, lat);
      check($sformatf("rand_lat d=%0d", v), longint'(lat), 4);
      check($sformatf("rand_code d=%0d", v), longint'(c), ref_code(8, longint'(v)));
      check($sformatf("rand_err d=%0d", v), longint'(e), longint'(v > 6'd54));
      take();
    end

    sweep_go = 1'b1;
    cnt = 0;
    while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done) && cnt < 5000) begin
      @(posedge clk); #1; cnt++;
    end
    check("sweep_complete",
          longint'(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done), 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
